// File: rtl/regfile_if.sv
// Register file bus: write-back write port, two decode read ports and a debug read port.
// master is the pipeline/debug side; slave is the register file.
interface regfile_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic              re1;
   logic [ADDR_W-1:0] raddr1;
   logic [DATA_W-1:0] rdata1;
   logic              re2;
   logic [ADDR_W-1:0] raddr2;
   logic [DATA_W-1:0] rdata2;
   logic [ADDR_W-1:0] dbg_raddr;
   logic [DATA_W-1:0] dbg_rdata;

   modport master (
      output we, waddr, wdata,
      output re1, raddr1, re2, raddr2, dbg_raddr,
      input  rdata1, rdata2, dbg_rdata
   );

   modport slave (
      input  we, waddr, wdata,
      input  re1, raddr1, re2, raddr2, dbg_raddr,
      output rdata1, rdata2, dbg_rdata
   );
endinterface

// File: rtl/regfile.sv
// MIPS32 general-purpose register file: 2 bypassed combinational read ports,
// 1 clocked write port and a committed-state-only debug read port. $0 is hardwired to zero.
module regfile #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int REG_NUM = 32
) (
   input  logic     clk,
   input  logic     rst,
   regfile_if.slave rf
);

   logic [DATA_W-1:0]  regs_reg [REG_NUM];
   logic [REG_NUM-1:0] wr_sel;
   logic [DATA_W-1:0]  rdata1_next;
   logic [DATA_W-1:0]  rdata2_next;
   logic [DATA_W-1:0]  dbg_rdata_next;

   // One-hot write decode; entry 0 can never be selected, so $0 stays at its reset value.
   assign wr_sel[0] = 1'b0;
   for (genvar gi = 1; gi < REG_NUM; gi++) begin : g_wr_sel
      assign wr_sel[gi] = rf.we && (rf.waddr == ADDR_W'(gi));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_NUM; i++) begin
            regs_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < REG_NUM; i++) begin
            if (wr_sel[i]) begin
               regs_reg[i] <= rf.wdata;
            end
         end
      end
   end

   // The write-through bypass only exists on the decode ports; debug sees committed state.
   always_comb begin
      rdata1_next    = '0;
      rdata2_next    = '0;
      dbg_rdata_next = '0;

      if (!rst && (rf.raddr1 != '0) && rf.re1) begin
         if (rf.we && (rf.raddr1 == rf.waddr)) begin
            rdata1_next = rf.wdata;
         end else begin
            rdata1_next = regs_reg[rf.raddr1];
         end
      end

      if (!rst && (rf.raddr2 != '0) && rf.re2) begin
         if (rf.we && (rf.raddr2 == rf.waddr)) begin
            rdata2_next = rf.wdata;
         end else begin
            rdata2_next = regs_reg[rf.raddr2];
         end
      end

      if (!rst && (rf.dbg_raddr != '0)) begin
         dbg_rdata_next = regs_reg[rf.dbg_raddr];
      end
   end

   assign rf.rdata1    = rdata1_next;
   assign rf.rdata2    = rdata2_next;
   assign rf.dbg_rdata = dbg_rdata_next;

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: reset, write/read, bypass, $0 protection,
// read disable, back-to-back writes and asynchronous mid-cycle reset.
module tb_regfile;
   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;

   regfile_if #(.DATA_W(32), .ADDR_W(5)) rf_bus ();

   regfile #(.DATA_W(32), .ADDR_W(5), .REG_NUM(32)) u_dut (
      .clk (clk),
      .rst (rst),
      .rf  (rf_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s got=%08h exp=%08h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s got=%08h", tag, got);
      end
   endtask

   task automatic idle_inputs();
      rf_bus.we        = 1'b0;
      rf_bus.waddr     = '0;
      rf_bus.wdata     = '0;
      rf_bus.re1       = 1'b0;
      rf_bus.raddr1    = '0;
      rf_bus.re2       = 1'b0;
      rf_bus.raddr2    = '0;
      rf_bus.dbg_raddr = '0;
   endtask

   // Write one register through a full clock cycle, leaving we low afterwards.
   task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
      @(negedge clk);
      rf_bus.we    = 1'b1;
      rf_bus.waddr = addr;
      rf_bus.wdata = data;
      @(negedge clk);
      rf_bus.we    = 1'b0;
   endtask

   initial begin
      #20000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      idle_inputs();

      // Reset holds all outputs low, even with a write aimed at the read address.
      @(negedge clk);
      rf_bus.re1       = 1'b1;
      rf_bus.raddr1    = 5'd5;
      rf_bus.re2       = 1'b1;
      rf_bus.raddr2    = 5'd31;
      rf_bus.dbg_raddr = 5'd7;
      rf_bus.we        = 1'b1;
      rf_bus.waddr     = 5'd5;
      rf_bus.wdata     = 32'hCAFE0005;
      #1;
      check("rst_rdata1", rf_bus.rdata1, 32'h0);
      check("rst_rdata2", rf_bus.rdata2, 32'h0);
      check("rst_dbg",    rf_bus.dbg_rdata, 32'h0);
      @(negedge clk);
      rf_bus.we = 1'b0;
      rst       = 1'b0;
      #1;
      check("rst_write_ignored_p1", rf_bus.rdata1, 32'h0);
      for (int i = 0; i < 32; i++) begin
         rf_bus.dbg_raddr = 5'(i);
         #1;
         check($sformatf("post_rst_dbg_r%0d", i), rf_bus.dbg_rdata, 32'h0);
      end

      // Write then read.
      write_reg(5'd3, 32'hDEADBEEF);
      rf_bus.re1       = 1'b1;
      rf_bus.raddr1    = 5'd3;
      rf_bus.dbg_raddr = 5'd3;
      #1;
      check("wr_rd_p1",  rf_bus.rdata1, 32'hDEADBEEF);
      check("wr_rd_dbg", rf_bus.dbg_rdata, 32'hDEADBEEF);

      // Bypass: both ports see new data, debug sees committed data.
      write_reg(5'd4, 32'h00000001);
      rf_bus.we        = 1'b1;
      rf_bus.waddr     = 5'd4;
      rf_bus.wdata     = 32'h12345678;
      rf_bus.re1       = 1'b1;
      rf_bus.raddr1    = 5'd4;
      rf_bus.re2       = 1'b1;
      rf_bus.raddr2    = 5'd4;
      rf_bus.dbg_raddr = 5'd4;
      #1;
      check("byp_p1",      rf_bus.rdata1, 32'h12345678);
      check("byp_p2",      rf_bus.rdata2, 32'h12345678);
      check("byp_dbg_old", rf_bus.dbg_rdata, 32'h00000001);
      @(negedge clk);
      rf_bus.we = 1'b0;
      #1;
      check("byp_dbg_new", rf_bus.dbg_rdata, 32'h12345678);
      check("byp_p1_stor", rf_bus.rdata1, 32'h12345678);

      // Independent addresses on the two ports.
      rf_bus.raddr1 = 5'd3;
      rf_bus.raddr2 = 5'd4;
      #1;
      check("split_p1", rf_bus.rdata1, 32'hDEADBEEF);
      check("split_p2", rf_bus.rdata2, 32'h12345678);

      // $0 protection.
      @(negedge clk);
      rf_bus.we        = 1'b1;
      rf_bus.waddr     = 5'd0;
      rf_bus.wdata     = 32'hFFFFFFFF;
      rf_bus.re1       = 1'b1;
      rf_bus.raddr1    = 5'd0;
      rf_bus.dbg_raddr = 5'd0;
      #1;
      check("r0_same_cyc", rf_bus.rdata1, 32'h0);
      @(negedge clk);
      rf_bus.we = 1'b0;
      #1;
      check("r0_next_cyc", rf_bus.rdata1, 32'h0);
      check("r0_dbg",      rf_bus.dbg_rdata, 32'h0);

      // Read disable on port 2, with and without a concurrent write.
      write_reg(5'd9, 32'hA5A5A5A5);
      rf_bus.re2    = 1'b0;
      rf_bus.raddr2 = 5'd9;
      #1;
      check("rdis_nowr", rf_bus.rdata2, 32'h0);
      rf_bus.we    = 1'b1;
      rf_bus.waddr = 5'd9;
      rf_bus.wdata = 32'h00000077;
      #1;
      check("rdis_wr", rf_bus.rdata2, 32'h0);
      @(negedge clk);
      rf_bus.we  = 1'b0;
      rf_bus.re2 = 1'b1;
      #1;
      check("ren_after", rf_bus.rdata2, 32'h00000077);

      // Back-to-back writes: intermediate value only visible through bypass.
      @(negedge clk);
      rf_bus.we        = 1'b1;
      rf_bus.waddr     = 5'd12;
      rf_bus.wdata     = 32'h00000111;
      rf_bus.re1       = 1'b1;
      rf_bus.raddr1    = 5'd12;
      rf_bus.dbg_raddr = 5'd12;
      @(negedge clk);
      rf_bus.wdata = 32'h00000222;
      #1;
      check("b2b_p1_byp", rf_bus.rdata1, 32'h00000222);
      check("b2b_dbg_mid", rf_bus.dbg_rdata, 32'h00000111);
      @(negedge clk);
      rf_bus.we = 1'b0;
      #1;
      check("b2b_p1_last", rf_bus.rdata1, 32'h00000222);
      check("b2b_dbg_last", rf_bus.dbg_rdata, 32'h00000222);

      // Asynchronous reset mid-cycle, with a write pending across the reset edge.
      write_reg(5'd10, 32'h00000055);
      rf_bus.re1       = 1'b1;
      rf_bus.raddr1    = 5'd10;
      rf_bus.dbg_raddr = 5'd10;
      #1;
      check("arst_pre", rf_bus.rdata1, 32'h00000055);
      #1;
      rst          = 1'b1;
      rf_bus.we    = 1'b1;
      rf_bus.waddr = 5'd11;
      rf_bus.wdata = 32'h0000BEEF;
      #1;
      check("arst_p1_drop",  rf_bus.rdata1, 32'h0);
      check("arst_dbg_drop", rf_bus.dbg_rdata, 32'h0);
      @(negedge clk);
      rst       = 1'b0;
      rf_bus.we = 1'b0;
      #1;
      check("arst_r10_clr", rf_bus.rdata1, 32'h0);
      rf_bus.dbg_raddr = 5'd11;
      #1;
      check("arst_r11_nowr", rf_bus.dbg_rdata, 32'h0);
      rf_bus.dbg_raddr = 5'd3;
      #1;
      check("arst_r3_clr", rf_bus.dbg_rdata, 32'h0);

      // First write after release is accepted.
      write_reg(5'd10, 32'h00000099);
      rf_bus.dbg_raddr = 5'd10;
      #1;
      check("post_arst_wr_p1",  rf_bus.rdata1, 32'h00000099);
      check("post_arst_wr_dbg", rf_bus.dbg_rdata, 32'h00000099);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
